// File: rtl/reset_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reset_sequencer_pkg
// Description : State encoding and shared constants for the reset sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package reset_sequencer_pkg;

    localparam int FAULT_STAGE_W = 3;

    localparam logic [2:0] S_HOLD     = 3'd0;
    localparam logic [2:0] S_WAIT_ACK = 3'd1;
    localparam logic [2:0] S_GAP      = 3'd2;
    localparam logic [2:0] S_DONE     = 3'd3;
    localparam logic [2:0] S_FAULT    = 3'd4;

    typedef enum logic [2:0] {
        ST_HOLD     = S_HOLD,
        ST_WAIT_ACK = S_WAIT_ACK,
        ST_GAP      = S_GAP,
        ST_DONE     = S_DONE,
        ST_FAULT    = S_FAULT
    } seq_state_t;

    // A domain stays held while its index is above the most recently released stage.
    function automatic logic stage_held(input int bit_idx, input logic [FAULT_STAGE_W-1:0] cur);
        return bit_idx > int'(cur);
    endfunction

endpackage : reset_sequencer_pkg
`default_nettype wire

// File: rtl/reset_sequencer_seq_timer.sv
`default_nettype none
// ============================================================================
// Module      : seq_timer
// Description : Up-counter with clear/enable and terminal-count compare
//               against (limit - 1); shared by the gap and timeout phases.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_timer
    import reset_sequencer_pkg::*;
#(
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             terminal
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign terminal = (count == (limit - CNT_W'(1)));

endmodule : seq_timer
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : reset_sequencer
// Description : Releases NUM_STAGES reset domains one at a time, waiting for
//               each Ready acknowledge and a settle gap before the next one.
// Revision    : 1.0 - initial release
// ============================================================================
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int NUM_STAGES     = 4,
    parameter int GAP_CYCLES     = 1000,
    parameter int TIMEOUT_CYCLES = 500000,
    parameter int CNT_W          = 20
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [NUM_STAGES-1:0]    Ready,
    input  logic                     Retry,
    output logic [NUM_STAGES-1:0]    StageReset,
    output logic                     Done,
    output logic                     Fault,
    output logic [FAULT_STAGE_W-1:0] FaultStage
);

    localparam logic [NUM_STAGES-1:0]    ALL_HELD      = {NUM_STAGES{1'b1}};
    localparam logic [FAULT_STAGE_W-1:0] LAST_STAGE    = FAULT_STAGE_W'(NUM_STAGES - 1);
    localparam logic [CNT_W-1:0]         TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    // One extra count so the gap spans GAP_CYCLES full cycles after the acknowledge cycle.
    localparam logic [CNT_W-1:0]         GAP_LIMIT     = CNT_W'(GAP_CYCLES + 1);

    seq_state_t                 state_q, state_d;
    logic [FAULT_STAGE_W-1:0]   stage_q, stage_d;
    logic [NUM_STAGES-1:0]      stage_reset_q, stage_reset_d;
    logic                       done_q, done_d;
    logic                       fault_q, fault_d;
    logic [FAULT_STAGE_W-1:0]   fault_stage_q, fault_stage_d;

    logic                       tmr_clear;
    logic                       tmr_enable;
    logic [CNT_W-1:0]           tmr_limit;
    logic                       tmr_tc;

    logic [7:0]                 ready_ext;
    logic                       all_ready;
    logic [FAULT_STAGE_W-1:0]   drop_idx;
    logic [FAULT_STAGE_W-1:0]   release_idx;
    logic [NUM_STAGES-1:0]      release_mask;

    seq_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (Clk),
        .rst      (Reset),
        .clear    (tmr_clear),
        .enable   (tmr_enable),
        .limit    (tmr_limit),
        .terminal (tmr_tc)
    );

    always_comb begin
        ready_ext                 = '0;
        ready_ext[NUM_STAGES-1:0] = Ready;
    end

    assign all_ready = &Ready;

    // Lowest-numbered domain that lost its acknowledge.
    always_comb begin
        drop_idx = '0;
        for (int j = NUM_STAGES - 1; j >= 0; j--) begin
            if (!Ready[j]) begin
                drop_idx = FAULT_STAGE_W'(j);
            end
        end
    end

    assign release_idx = (state_q == ST_GAP) ? (stage_q + FAULT_STAGE_W'(1)) : '0;

    always_comb begin
        release_mask = '0;
        for (int b = 0; b < NUM_STAGES; b++) begin
            release_mask[b] = stage_held(b, release_idx);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= ST_HOLD;
            stage_q       <= '0;
            stage_reset_q <= ALL_HELD;
            done_q        <= 1'b0;
            fault_q       <= 1'b0;
            fault_stage_q <= '0;
        end else begin
            state_q       <= state_d;
            stage_q       <= stage_d;
            stage_reset_q <= stage_reset_d;
            done_q        <= done_d;
            fault_q       <= fault_d;
            fault_stage_q <= fault_stage_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        stage_d       = stage_q;
        stage_reset_d = stage_reset_q;
        done_d        = done_q;
        fault_d       = fault_q;
        fault_stage_d = fault_stage_q;
        tmr_clear     = 1'b0;
        tmr_enable    = 1'b0;
        tmr_limit     = TIMEOUT_LIMIT;

        case (state_q)
            ST_HOLD: begin
                state_d       = ST_WAIT_ACK;
                stage_d       = '0;
                stage_reset_d = release_mask;
                done_d        = 1'b0;
                fault_d       = 1'b0;
                tmr_clear     = 1'b1;
            end

            // An acknowledge arriving on the timeout cycle still counts.
            ST_WAIT_ACK: begin
                if (ready_ext[stage_q]) begin
                    if (stage_q == LAST_STAGE) begin
                        state_d       = ST_DONE;
                        done_d        = 1'b1;
                        stage_reset_d = '0;
                    end else begin
                        state_d   = ST_GAP;
                        tmr_clear = 1'b1;
                    end
                end else if (tmr_tc) begin
                    state_d       = ST_FAULT;
                    fault_d       = 1'b1;
                    fault_stage_d = stage_q;
                    stage_reset_d = ALL_HELD;
                end else begin
                    tmr_enable = 1'b1;
                end
            end

            ST_GAP: begin
                tmr_limit = GAP_LIMIT;
                if (tmr_tc) begin
                    state_d       = ST_WAIT_ACK;
                    stage_d       = stage_q + FAULT_STAGE_W'(1);
                    stage_reset_d = release_mask;
                    tmr_clear     = 1'b1;
                end else begin
                    tmr_enable = 1'b1;
                end
            end

            ST_DONE: begin
                if (!all_ready) begin
                    state_d       = ST_FAULT;
                    done_d        = 1'b0;
                    fault_d       = 1'b1;
                    fault_stage_d = drop_idx;
                    stage_reset_d = ALL_HELD;
                end
            end

            ST_FAULT: begin
                if (Retry) begin
                    state_d       = ST_HOLD;
                    stage_d       = '0;
                    fault_d       = 1'b0;
                    fault_stage_d = '0;
                end
            end

            default: begin
                state_d = ST_HOLD;
            end
        endcase
    end

    assign StageReset = stage_reset_q;
    assign Done       = done_q;
    assign Fault      = fault_q;
    assign FaultStage = fault_stage_q;

endmodule : reset_sequencer
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reset_sequencer
// Description : Scoreboard bench: predicted output changes are queued as
//               stimulus is driven and compared against observed changes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reset_sequencer;

    typedef struct packed {
        logic [31:0] cyc;
        logic [3:0]  sr;
        logic        done;
        logic        fault;
        logic [2:0]  fs;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] ready = 4'h0;
    logic       retry = 1'b0;
    logic [3:0] stage_reset;
    logic       done;
    logic       fault;
    logic [2:0] fault_stage;

    logic [31:0] cyc = 32'd0;
    int          n_tests = 0;
    int          n_fail = 0;
    obs_t        exp_q[$];
    obs_t        obs_q[$];
    logic [8:0]  last_bits = 'x;

    reset_sequencer #(
        .NUM_STAGES     (4),
        .GAP_CYCLES     (8),
        .TIMEOUT_CYCLES (32),
        .CNT_W          (20)
    ) dut (
        .Clk        (clk),
        .Reset      (rst),
        .Ready      (ready),
        .Retry      (retry),
        .StageReset (stage_reset),
        .Done       (done),
        .Fault      (fault),
        .FaultStage (fault_stage)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 32'd1;

    // Record every change of the visible outputs; FaultStage only matters while Fault is high.
    always @(negedge clk) begin
        obs_t cur;
        cur.cyc   = cyc;
        cur.sr    = stage_reset;
        cur.done  = done;
        cur.fault = fault;
        cur.fs    = fault ? fault_stage : 3'd0;
        if ({cur.sr, cur.done, cur.fault, cur.fs} !== last_bits) begin
            obs_q.push_back(cur);
            last_bits = {cur.sr, cur.done, cur.fault, cur.fs};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got %0d cycles, want completion", cyc);
        $fatal(1);
    end

    function automatic string fmt(obs_t v);
        return $sformatf("cyc=%0d sr=%b done=%b fault=%b fs=%0d", v.cyc, v.sr, v.done, v.fault, v.fs);
    endfunction

    function automatic void expect_at(logic [31:0] c, logic [3:0] sr, logic d, logic f, logic [2:0] fs);
        obs_t e;
        e.cyc = c; e.sr = sr; e.done = d; e.fault = f; e.fs = fs;
        exp_q.push_back(e);
    endfunction

    function automatic logic [3:0] rel_mask(int k);
        logic [3:0] m;
        m = 4'hF;
        return m << (k + 1);
    endfunction

    task automatic wait_until(input logic [31:0] t);
        while (cyc < t) @(negedge clk);
    endtask

    // Walk stages from release of stage 0 at rel0; stage 1 acks dly1 cycles after release,
    // the others after 3. Stages at or beyond n_ack never ack and must time out.
    task automatic drive_seq(input logic [31:0] rel0, input int dly1, input int n_ack);
        logic [31:0] rel;
        int          d;
        rel = rel0;
        for (int k = 0; k < 4; k++) begin
            expect_at(rel, rel_mask(k), 1'b0, 1'b0, 3'd0);
            if (k >= n_ack) begin
                expect_at(rel + 32'd32, 4'hF, 1'b0, 1'b1, 3'(k));
                wait_until(rel + 32'd33);
                return;
            end
            d = (k == 1) ? dly1 : 3;
            wait_until(rel + 32'(d));
            ready[k] = 1'b1;
            if (k == 3) begin
                expect_at(rel + 32'(d) + 32'd1, 4'h0, 1'b1, 1'b0, 3'd0);
                wait_until(rel + 32'(d) + 32'd3);
            end else begin
                rel = rel + 32'(d) + 32'd10;
            end
        end
    endtask

    task automatic test_reset();
        repeat (5) begin
            @(negedge clk);
            n_tests++;
            if ({stage_reset, done, fault, fault_stage} !== {4'hF, 1'b0, 1'b0, 3'd0}) begin
                n_fail++;
                $display("FAIL reset_hold: got sr=%b done=%b fault=%b fs=%0d, want sr=1111 done=0 fault=0 fs=0",
                         stage_reset, done, fault, fault_stage);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_sequence();
        obs_t e, o;
        rst = 1'b0;
        drive_seq(cyc + 32'd1, 3, 4);
        @(negedge clk); #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_q.size() == 0) begin
                n_fail++; $display("FAIL sequence: got no change, want %s", fmt(e));
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL sequence: got %s, want %s", fmt(o), fmt(e)); end
            end
        end
        n_tests++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL sequence_extra: got %s, want no change", fmt(obs_q[0])); end
        obs_q.delete();
    endtask

    task automatic test_done_drop();
        obs_t e, o;
        @(negedge clk);
        ready[1] = 1'b0;
        expect_at(cyc + 32'd1, 4'hF, 1'b0, 1'b1, 3'd1);
        repeat (3) @(negedge clk);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_q.size() == 0) begin
                n_fail++; $display("FAIL done_drop: got no change, want %s", fmt(e));
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL done_drop: got %s, want %s", fmt(o), fmt(e)); end
            end
        end
        n_tests++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL done_drop_extra: got %s, want no change", fmt(obs_q[0])); end
        obs_q.delete();
    endtask

    // Retry from FAULT; stage 1 acks on the exact timeout cycle; Retry in DONE is ignored.
    task automatic test_retry();
        obs_t e, o;
        @(negedge clk);
        ready = 4'h0;
        retry = 1'b1;
        expect_at(cyc + 32'd1, 4'hF, 1'b0, 1'b0, 3'd0);
        @(negedge clk);
        retry = 1'b0;
        drive_seq(cyc + 32'd1, 31, 4);
        @(negedge clk); retry = 1'b1;
        @(negedge clk); retry = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_q.size() == 0) begin
                n_fail++; $display("FAIL retry: got no change, want %s", fmt(e));
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL retry: got %s, want %s", fmt(o), fmt(e)); end
            end
        end
        n_tests++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL retry_extra: got %s, want no change", fmt(obs_q[0])); end
        obs_q.delete();
    endtask

    // Stage 2 never acks; stage 3 acks early and must be ignored.
    task automatic test_timeout();
        obs_t e, o;
        @(negedge clk);
        ready = 4'b1000;
        rst   = 1'b1;
        expect_at(cyc + 32'd1, 4'hF, 1'b0, 1'b0, 3'd0);
        @(negedge clk);
        rst = 1'b0;
        drive_seq(cyc + 32'd1, 3, 2);
        @(negedge clk); #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_q.size() == 0) begin
                n_fail++; $display("FAIL timeout: got no change, want %s", fmt(e));
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL timeout: got %s, want %s", fmt(o), fmt(e)); end
            end
        end
        n_tests++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL timeout_extra: got %s, want no change", fmt(obs_q[0])); end
        obs_q.delete();
    endtask

    task automatic test_reset_mid_gap();
        obs_t        e, o;
        logic [31:0] rel0, rel1;
        @(negedge clk);
        ready = 4'h0;
        rst   = 1'b1;
        expect_at(cyc + 32'd1, 4'hF, 1'b0, 1'b0, 3'd0);
        @(negedge clk);
        rst  = 1'b0;
        rel0 = cyc + 32'd1;
        expect_at(rel0, 4'b1110, 1'b0, 1'b0, 3'd0);
        wait_until(rel0 + 32'd3);
        ready[0] = 1'b1;
        rel1 = rel0 + 32'd13;
        expect_at(rel1, 4'b1100, 1'b0, 1'b0, 3'd0);
        wait_until(rel1 + 32'd3);
        ready[1] = 1'b1;
        wait_until(rel1 + 32'd8);
        rst   = 1'b1;
        ready = 4'h0;
        expect_at(rel1 + 32'd9, 4'hF, 1'b0, 1'b0, 3'd0);
        @(negedge clk);
        rst = 1'b0;
        drive_seq(cyc + 32'd1, 3, 4);
        @(negedge clk); #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_q.size() == 0) begin
                n_fail++; $display("FAIL mid_gap_reset: got no change, want %s", fmt(e));
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL mid_gap_reset: got %s, want %s", fmt(o), fmt(e)); end
            end
        end
        n_tests++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL mid_gap_extra: got %s, want no change", fmt(obs_q[0])); end
        obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_done_drop();
        test_retry();
        test_timeout();
        test_reset_mid_gap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_reset_sequencer
`default_nettype wire
